// File: rtl/stepper_array.sv
// rtl/stepper_array.sv - N-channel step/dir generator with accel-limited ramp and shared active-low enable
// Define STEPPER_POS_COUNT_EN to add per-channel signed step position counters (pos, pos_clear).
module stepper_array #(
  parameter int NUM_CH     = 2,
  parameter int SPEED_W    = 10,
  parameter int MAX_SPEED  = 500,
  parameter int ACC_W      = 24,
  parameter int RAMP_DIV   = 100000,
  parameter int ACCEL_STEP = 4,
  parameter int PULSE_W    = 200,
  parameter int DIR_SETUP  = 100,
  parameter int EN_HOLD    = 1000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      run_en,
  input  logic                      estop,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [$clog2(NUM_CH)-1:0] cmd_ch,
  input  logic signed [SPEED_W-1:0] cmd_speed,
  output logic [NUM_CH-1:0]         step,
  output logic [NUM_CH-1:0]         dir,
  output logic                      en_n,
  output logic [NUM_CH-1:0]         moving,
  output logic [NUM_CH-1:0]         at_target
`ifdef STEPPER_POS_COUNT_EN
  ,
  input  logic                      pos_clear,
  output logic [32*NUM_CH-1:0]      pos
`endif
);

  localparam int RD_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV + 1) : 1;
  localparam int SU_W  = (DIR_SETUP > 0) ? $clog2(DIR_SETUP + 1) : 1;
  localparam int PW_W  = (PULSE_W > 1) ? $clog2(PULSE_W + 1) : 1;
  localparam int EH_W  = (EN_HOLD > 1) ? $clog2(EN_HOLD + 1) : 1;
  localparam int SUM_W = ACC_W + SPEED_W;
  localparam logic signed [SPEED_W-1:0] MAX_S  = SPEED_W'(MAX_SPEED);
  localparam logic signed [SPEED_W-1:0] STEP_S = SPEED_W'(ACCEL_STEP);
  localparam logic signed [SPEED_W:0]   STEP_D = (SPEED_W + 1)'(ACCEL_STEP);

  logic                      rdy_q;
  logic                      cmd_fire;
  logic signed [SPEED_W-1:0] cmd_sat;
  logic [RD_W-1:0]           ramp_cnt;
  logic                      tick;
  logic [NUM_CH-1:0]         cur_nz;
  logic [EH_W-1:0]           idle_cnt;
  logic                      active;

  // estop must block a command even in the cycle it first asserts
  assign cmd_ready = rdy_q & ~estop;
  assign cmd_fire  = cmd_valid & cmd_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rdy_q <= 1'b0;
    else       rdy_q <= 1'b1;
  end

  always_comb begin
    cmd_sat = cmd_speed;
    if (cmd_speed > MAX_S)       cmd_sat = MAX_S;
    else if (cmd_speed < -MAX_S) cmd_sat = -MAX_S;
  end

  assign tick = (ramp_cnt == RD_W'(RAMP_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     ramp_cnt <= '0;
    else if (tick) ramp_cnt <= '0;
    else           ramp_cnt <= ramp_cnt + 1'b1;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [SPEED_W-1:0] tgt, eff, cur, goal, nxt;
    logic signed [SPEED_W:0]   diff;
    logic [SPEED_W-1:0]        mag;
    logic [ACC_W-1:0]          acc;
    logic [SUM_W-1:0]          sum;
    logic [SU_W-1:0]           su_cnt;
    logic [PW_W-1:0]           pw_cnt;
    logic                      dir_q, step_q, moving_q, at_q;
    logic                      new_dir, rev, depart, adv, carry;

    assign eff       = (estop | ~run_en) ? '0 : tgt;
    assign mag       = cur[SPEED_W-1] ? $unsigned(-cur) : $unsigned(cur);
    assign sum       = SUM_W'(acc) + SUM_W'(mag);
    assign adv       = (cur != '0) && (su_cnt == '0);
    assign carry     = adv && (sum[SUM_W-1:ACC_W] != '0);
    assign new_dir   = ~goal[SPEED_W-1];
    assign rev       = (new_dir != dir_q);
    // leaving zero the other way waits for the current pulse to finish
    assign depart    = tick && (cur == '0) && (goal != '0) && !(rev && step_q);
    assign cur_nz[c] = (cur != '0);

    assign dir[c]       = dir_q;
    assign step[c]      = step_q;
    assign moving[c]    = moving_q;
    assign at_target[c] = at_q;

    // a moving channel facing an opposite-sign target heads to 0 first
    always_comb begin
      goal = eff;
      if (cur != '0 && (eff == '0 || eff[SPEED_W-1] != cur[SPEED_W-1])) goal = '0;
      diff = (SPEED_W + 1)'(goal) - (SPEED_W + 1)'(cur);
      if (diff > STEP_D)       nxt = cur + STEP_S;
      else if (diff < -STEP_D) nxt = cur - STEP_S;
      else                     nxt = goal;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        tgt      <= '0;
        cur      <= '0;
        acc      <= '0;
        su_cnt   <= '0;
        pw_cnt   <= '0;
        dir_q    <= 1'b1;
        step_q   <= 1'b0;
        moving_q <= 1'b0;
        at_q     <= 1'b1;
      end else begin
        if (cmd_fire && 32'(cmd_ch) == c) tgt <= cmd_sat;
        moving_q <= (cur != '0);
        at_q     <= (cur == eff);
        if (depart) begin
          cur    <= nxt;
          dir_q  <= new_dir;
          su_cnt <= SU_W'(DIR_SETUP);
          if (rev) acc <= '0;
        end else begin
          if (tick && cur != '0) cur <= nxt;
          if (su_cnt != '0)      su_cnt <= su_cnt - 1'b1;
          if (adv)               acc <= sum[ACC_W-1:0];
        end
        // carries landing inside a pulse are dropped
        if (step_q) begin
          if (pw_cnt == '0) step_q <= 1'b0;
          else              pw_cnt <= pw_cnt - 1'b1;
        end else if (carry) begin
          step_q <= 1'b1;
          pw_cnt <= PW_W'(PULSE_W - 1);
        end
      end
    end

`ifdef STEPPER_POS_COUNT_EN
    logic        step_d;
    logic [31:0] pos_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        step_d <= 1'b0;
        pos_q  <= '0;
      end else begin
        step_d <= step_q;
        if (pos_clear)              pos_q <= '0;
        else if (step_q && !step_d) pos_q <= dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
      end
    end

    assign pos[32*c +: 32] = pos_q;
`endif
  end

  assign active = (|cur_nz) | (|step);

  // en_n release ignores estop so decelerating motors stay powered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_n     <= 1'b1;
      idle_cnt <= '0;
    end else if (active) begin
      en_n     <= 1'b0;
      idle_cnt <= '0;
    end else if (!en_n) begin
      if (idle_cnt == EH_W'(EN_HOLD - 1)) begin
        en_n     <= 1'b1;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stepper_array.sv
// tb/tb_stepper_array.sv - directed self-checking bench for stepper_array
module tb_stepper_array;

  localparam int NUM_CH = 2;
  localparam int SPEED_W = 11;

  logic clock = 1'b0;
  logic reset, run_en, estop, cmd_valid, cmd_ready;
  logic [0:0] cmd_ch;
  logic signed [SPEED_W-1:0] cmd_speed;
  logic [NUM_CH-1:0] step, dir, moving, at_target;
  logic en_n;
`ifdef STEPPER_POS_COUNT_EN
  logic pos_clear;
  logic [32*NUM_CH-1:0] pos;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n, r0;

  always #5 clock = ~clock;

  stepper_array #(
    .NUM_CH(NUM_CH), .SPEED_W(SPEED_W), .MAX_SPEED(500), .ACC_W(8), .RAMP_DIV(4),
    .ACCEL_STEP(2), .PULSE_W(3), .DIR_SETUP(5), .EN_HOLD(20)
  ) dut (
    .clock(clock), .reset(reset), .run_en(run_en), .estop(estop),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_speed(cmd_speed),
    .step(step), .dir(dir), .en_n(en_n), .moving(moving), .at_target(at_target)
`ifdef STEPPER_POS_COUNT_EN
    , .pos_clear(pos_clear), .pos(pos)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic logic sig(input int which, input int ch);
    case (which)
      0:       return step[ch];
      1:       return moving[ch];
      2:       return at_target[ch];
      default: return en_n;
    endcase
  endfunction

  // cycles until the selected output reads v; -1 if the budget runs out
  task automatic wait_val(input int which, input int ch, input logic v, input int max, output int cnt);
    cnt = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clock);
      if (sig(which, ch) === v) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic step_rise(input int ch, input int max, output int cnt);
    logic prev;
    prev = step[ch];
    cnt = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clock);
      if (step[ch] === 1'b1 && prev === 1'b0) begin
        cnt = i;
        break;
      end
      prev = step[ch];
    end
  endtask

  task automatic high_width(input int ch, output int cnt);
    cnt = 0;
    while (step[ch] === 1'b1 && cnt < 50) begin
      @(negedge clock);
      cnt++;
    end
  endtask

  task automatic send(input int ch, input int spd);
    cmd_ch    = 1'(ch);
    cmd_speed = SPEED_W'(spd);
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run_en = 1'b1; estop = 1'b0;
    cmd_valid = 1'b0; cmd_ch = '0; cmd_speed = '0;
`ifdef STEPPER_POS_COUNT_EN
    pos_clear = 1'b0;
`endif
    repeat (3) @(negedge clock);
    chk("rst_step", 64'(step), 64'd0);
    chk("rst_dir", 64'(dir), 64'd3);
    chk("rst_en_n", 64'(en_n), 64'd1);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_moving", 64'(moving), 64'd0);
    chk("rst_at_target", 64'(at_target), 64'd3);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);
    chk("en_n_idle", 64'(en_n), 64'd1);

    // ch0 to +16: 2 per tick, 8 ticks
    send(0, 16);
    repeat (8) @(negedge clock);
    chk("fwd_ramping", 64'(at_target[0]), 64'd0);
    chk("fwd_moving", 64'(moving[0]), 64'd1);
    chk("fwd_en_n", 64'(en_n), 64'd0);
    chk("fwd_dir", 64'(dir[0]), 64'd1);
    wait_val(2, 0, 1'b1, 60, n);
    chk_rng("fwd_reach_time", n, 22, 25);
    step_rise(0, 40, r0);
    step_rise(0, 40, n);
    chk("fwd_period", 64'(n), 64'd16);
    high_width(0, n);
    chk("fwd_pulse_w", 64'(n), 64'd3);
    step_rise(0, 40, n);
    chk("fwd_low_gap", 64'(n), 64'd13);

    // reversal to -16 through a dwell at 0
    send(0, -16);
    wait_val(1, 0, 1'b0, 60, n);
    chk_rng("rev_reach_zero", n, 30, 33);
    chk("rev_dir_held", 64'(dir[0]), 64'd1);
    wait_val(1, 0, 1'b1, 20, n);
    chk_rng("rev_zero_dwell", n, 4, 8);
    chk("rev_dir", 64'(dir[0]), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("rev_setup_nostep", 64'(step[0]), 64'd0);
    end
    wait_val(2, 0, 1'b1, 40, n);
    chk("rev_reach_time", 64'(n), 64'd23);
    step_rise(0, 40, r0);
    step_rise(0, 40, n);
    chk("rev_period", 64'(n), 64'd16);
    chk("rev_dir_run", 64'(dir[0]), 64'd0);

    // ch1 to +600 clamps at 500
    send(1, 600);
    wait_val(2, 1, 1'b1, 1100, n);
    chk_rng("clamp_reach_time", n, 998, 1001);
    repeat (40) @(negedge clock);
    chk("clamp_hold", 64'(at_target[1]), 64'd1);
    step_rise(1, 20, r0);
    step_rise(1, 20, n);
    chk("sat_period", 64'(n), 64'd4);
    high_width(1, n);
    chk("sat_pulse_w", 64'(n), 64'd3);

    send(1, 0);
    send(0, 16);
    wait_val(1, 1, 1'b0, 1100, n);
    chk_rng("ch1_stop", n, 1, 1100);
    wait_val(2, 0, 1'b1, 100, n);
    chk("both_at_target", 64'(at_target), 64'd3);
    chk("ch0_dir_fwd", 64'(dir[0]), 64'd1);

    // estop with a simultaneous command that must be dropped
    estop = 1'b1; cmd_valid = 1'b1; cmd_ch = 1'b0; cmd_speed = SPEED_W'(-100);
    #1 chk("estop_ready_now", 64'(cmd_ready), 64'd0);
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("estop_ready", 64'(cmd_ready), 64'd0);
    wait_val(1, 0, 1'b0, 60, n);
    chk_rng("estop_stop", n, 1, 60);
    chk("estop_en_held", 64'(en_n), 64'd0);
    wait_val(3, 0, 1'b1, 40, n);
    chk_rng("en_hold_time", n, 19, 23);
    estop = 1'b0;
    @(negedge clock);
    chk("release_ready", 64'(cmd_ready), 64'd1);
    wait_val(2, 0, 1'b1, 60, n);
    chk_rng("release_reach", n, 29, 32);
    chk("release_dir", 64'(dir[0]), 64'd1);
    chk("release_en_n", 64'(en_n), 64'd0);

    // run_en low forces target 0, stored target resumes
    run_en = 1'b0;
    wait_val(1, 0, 1'b0, 60, n);
    chk_rng("run_en_stop", n, 1, 60);
    chk("run_en_at_zero", 64'(at_target[0]), 64'd1);
    run_en = 1'b1;
    wait_val(2, 0, 1'b1, 60, n);
    chk_rng("run_en_resume", n, 30, 33);

`ifdef STEPPER_POS_COUNT_EN
    step_rise(0, 40, n);
    pos_clear = 1'b1;
    @(negedge clock);
    pos_clear = 1'b0;
    chk("pos_clear_wins", 64'(pos[31:0]), 64'd0);
    for (int i = 0; i < 10; i++) step_rise(0, 40, n);
    @(negedge clock);
    chk("pos_count10", 64'(pos[31:0]), 64'd10);
    chk("pos_ch1", 64'(pos[63:32]), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
